hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 30 +++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: pipeline register fields in, stall/flush/forward controls
// and status out.
interface hazard_ctrl_if;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        ex_mem_read, mem_reg_write, wb_reg_write;
  logic        ex_branch_taken, mem_access, dmem_ready, clr_cnt;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic        if_id_flush, id_ex_flush, mem_wb_flush;
  logic [1:0]  fwd_a, fwd_b, state;
  logic        mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  modport master (
    output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
           ex_mem_read, mem_reg_write, wb_reg_write,
           ex_branch_taken, mem_access, dmem_ready, clr_cnt,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en,
           if_id_flush, id_ex_flush, mem_wb_flush,
           fwd_a, fwd_b, state, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
           ex_mem_read, mem_reg_write, wb_reg_write,
           ex_branch_taken, mem_access, dmem_ready, clr_cnt,
    output pc_en, if_id_en, id_ex_en, ex_mem_en,
           if_id_flush, id_ex_flush, mem_wb_flush,
           fwd_a, fwd_b, state, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard unit: operand forwarding, load-use stall, branch flush,
// data-memory wait freeze with timeout fault, and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FAULT    = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W:0]   wait_inc;
  logic              not_ready, freeze, load_use, wait_expire;
  logic              branch_apply, load_use_apply, stall_inc;

  // EX/MEM result is younger than MEM/WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic [4:0] w_rd, input logic w_we);
    if (m_we && (m_rd != 5'd0) && (m_rd == rs))
      return 2'b10;
    else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign hz.fwd_a = fwd_sel(hz.ex_rs1, hz.mem_rd, hz.mem_reg_write, hz.wb_rd, hz.wb_reg_write);
  assign hz.fwd_b = fwd_sel(hz.ex_rs2, hz.mem_rd, hz.mem_reg_write, hz.wb_rd, hz.wb_reg_write);

  assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                    ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));

  assign not_ready      = hz.mem_access && !hz.dmem_ready;
  assign freeze         = (state_q == FAULT) || not_ready;
  assign branch_apply   = !freeze && hz.ex_branch_taken;
  assign load_use_apply = !freeze && !hz.ex_branch_taken && load_use;
  assign stall_inc      = load_use_apply || (freeze && (state_q != FAULT));

  assign wait_inc    = {1'b0, wait_cnt} + {{WAIT_W{1'b0}}, 1'b1};
  assign wait_expire = (wait_inc == (WAIT_W + 1)'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (not_ready)
          state_d = wait_expire ? FAULT : MEM_WAIT;
        else
          state_d = RUN;
      end
      FAULT:   state_d = FAULT;
      default: state_d = RUN;
    endcase
  end

  // Freeze outranks branch, which outranks load-use; a branch squashes the stalled instruction anyway.
  always_comb begin
    hz.pc_en        = 1'b1;
    hz.if_id_en     = 1'b1;
    hz.id_ex_en     = 1'b1;
    hz.ex_mem_en    = 1'b1;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_flush  = 1'b0;
    hz.mem_wb_flush = 1'b0;
    if (freeze) begin
      hz.pc_en        = 1'b0;
      hz.if_id_en     = 1'b0;
      hz.id_ex_en     = 1'b0;
      hz.ex_mem_en    = 1'b0;
      hz.mem_wb_flush = 1'b1;
    end else if (branch_apply) begin
      hz.if_id_flush = 1'b1;
      hz.id_ex_flush = 1'b1;
    end else if (load_use_apply) begin
      hz.pc_en       = 1'b0;
      hz.if_id_en    = 1'b0;
      hz.id_ex_flush = 1'b1;
    end
  end

  assign hz.state       = state_q;
  assign hz.mem_timeout = (state_q == FAULT);

  // Counts consecutive not-ready cycles; held once in FAULT so it cannot wrap.
  always_ff @(posedge clk) begin
    if (rst || !freeze)
      wait_cnt <= '0;
    else if (not_ready && (state_q != FAULT))
      wait_cnt <= wait_inc[WAIT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || hz.clr_cnt) begin
      hz.stall_cnt <= 16'd0;
      hz.flush_cnt <= 16'd0;
    end else begin
      if (stall_inc && (hz.stall_cnt != 16'hFFFF))
        hz.stall_cnt <= hz.stall_cnt + 16'd1;
      if (branch_apply && (hz.flush_cnt != 16'hFFFF))
        hz.flush_cnt <= hz.flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a rule-level reference model.
module tb_hazard_ctrl;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Reference model: 0 run, 1 waiting on memory, 2 faulted
  int m_state = 0;
  int m_wait  = 0;
  int m_stall = 0;
  int m_flush = 0;

  hazard_ctrl_if hif ();
  hazard_ctrl #(.MEM_TIMEOUT(T)) dut (.clk(clk), .rst(rst), .hz(hif));

  always #5 clk = ~clk;

  function automatic logic exp_load_use();
    return hif.ex_mem_read && (hif.ex_rd != 5'd0) &&
           ((hif.ex_rd == hif.id_rs1) || (hif.ex_rd == hif.id_rs2));
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (hif.mem_reg_write && hif.mem_rd != 5'd0 && hif.mem_rd == rs) return 2'b10;
    if (hif.wb_reg_write && hif.wb_rd != 5'd0 && hif.wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush}
  function automatic logic [6:0] exp_ctrl();
    if (m_state == 2 || (hif.mem_access && !hif.dmem_ready)) return 7'b0000_001;
    if (hif.ex_branch_taken) return 7'b1111_110;
    if (exp_load_use()) return 7'b0011_010;
    return 7'b1111_000;
  endfunction

  function automatic logic [6:0] dut_ctrl();
    return {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en,
            hif.if_id_flush, hif.id_ex_flush, hif.mem_wb_flush};
  endfunction

  // Advance the model by one edge using the inputs currently driven, then clock the DUT.
  task automatic tick();
    logic nr, frz;
    nr  = hif.mem_access && !hif.dmem_ready;
    frz = (m_state == 2) || nr;
    if (rst) begin
      m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (hif.clr_cnt) begin
        m_stall = 0; m_flush = 0;
      end else begin
        if (((exp_load_use() && !hif.ex_branch_taken && !frz) || (frz && m_state != 2)) &&
            m_stall < 65535)
          m_stall++;
        if (hif.ex_branch_taken && !frz && m_flush < 65535)
          m_flush++;
      end
      if (m_state != 2) begin
        if (nr) begin
          if (m_wait + 1 == T) m_state = 2;
          else begin m_state = 1; m_wait++; end
        end else begin
          m_state = 0; m_wait = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hif.id_rs1 = 5'd0; hif.id_rs2 = 5'd0; hif.ex_rs1 = 5'd0; hif.ex_rs2 = 5'd0;
    hif.ex_rd = 5'd0; hif.mem_rd = 5'd0; hif.wb_rd = 5'd0;
    hif.ex_mem_read = 1'b0; hif.mem_reg_write = 1'b0; hif.wb_reg_write = 1'b0;
    hif.ex_branch_taken = 1'b0; hif.mem_access = 1'b0; hif.dmem_ready = 1'b1;
    hif.clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hif.mem_access = 1'b1; hif.dmem_ready = 1'b0; hif.ex_branch_taken = 1'b1;
    tick();
    checks++;
    if (hif.state !== 2'b00) begin errors++; $display("[TB] FAIL reset_state got %b expected 00", hif.state); end
    checks++;
    if (hif.mem_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got %b expected 0", hif.mem_timeout); end
    checks++;
    if (hif.stall_cnt !== 16'd0 || hif.flush_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_counters got %0d/%0d expected 0/0", hif.stall_cnt, hif.flush_cnt);
    end
    // Reset still held: comb outputs follow normal rules from the RUN state
    checks++;
    if (dut_ctrl() !== 7'b0000_001) begin errors++; $display("[TB] FAIL reset_comb_freeze got %b expected 0000001", dut_ctrl()); end
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (dut_ctrl() !== 7'b1111_000) begin errors++; $display("[TB] FAIL reset_normal got %b expected 1111000", dut_ctrl()); end
  endtask

  task automatic test_forwarding();
    idle_inputs();
    hif.mem_rd = 5'd7; hif.wb_rd = 5'd7; hif.mem_reg_write = 1'b1; hif.wb_reg_write = 1'b1;
    hif.ex_rs1 = 5'd7; hif.ex_rs2 = 5'd7;
    #1;
    checks++;
    if (hif.fwd_a !== 2'b10) begin errors++; $display("[TB] FAIL fwd_exmem got %b expected 10", hif.fwd_a); end
    hif.mem_reg_write = 1'b0;
    #1;
    checks++;
    if (hif.fwd_a !== 2'b01) begin errors++; $display("[TB] FAIL fwd_memwb got %b expected 01", hif.fwd_a); end
    hif.mem_reg_write = 1'b1; hif.ex_rs1 = 5'd0; hif.mem_rd = 5'd0; hif.wb_rd = 5'd0;
    #1;
    checks++;
    if (hif.fwd_a !== 2'b00) begin errors++; $display("[TB] FAIL fwd_zero got %b expected 00", hif.fwd_a); end
    hif.mem_rd = 5'd4; hif.wb_rd = 5'd9; hif.ex_rs2 = 5'd9;
    #1;
    checks++;
    if (hif.fwd_b !== 2'b01) begin errors++; $display("[TB] FAIL fwd_b_memwb got %b expected 01", hif.fwd_b); end
    tick();
  endtask

  task automatic test_load_use();
    int s0;
    idle_inputs();
    s0 = m_stall;
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd5; hif.id_rs2 = 5'd5;
    #1;
    checks++;
    if (dut_ctrl() !== 7'b0011_010) begin errors++; $display("[TB] FAIL load_use_ctrl got %b expected 0011010", dut_ctrl()); end
    tick();
    hif.ex_mem_read = 1'b0; hif.ex_rd = 5'd0;
    #1;
    checks++;
    if (dut_ctrl() !== 7'b1111_000) begin errors++; $display("[TB] FAIL load_use_once got %b expected 1111000", dut_ctrl()); end
    checks++;
    if (hif.stall_cnt !== 16'(s0 + 1)) begin errors++; $display("[TB] FAIL load_use_stall got %0d expected %0d", hif.stall_cnt, s0 + 1); end
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd0; hif.id_rs2 = 5'd0;
    #1;
    checks++;
    if (dut_ctrl() !== 7'b1111_000) begin errors++; $display("[TB] FAIL load_use_x0 got %b expected 1111000", dut_ctrl()); end
    tick();
    checks++;
    if (hif.stall_cnt !== 16'(s0 + 1)) begin errors++; $display("[TB] FAIL load_use_x0_cnt got %0d expected %0d", hif.stall_cnt, s0 + 1); end
  endtask

  task automatic test_branch();
    int s0, f0;
    idle_inputs();
    s0 = m_stall; f0 = m_flush;
    hif.ex_branch_taken = 1'b1; hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd3; hif.id_rs1 = 5'd3;
    #1;
    checks++;
    if (dut_ctrl() !== 7'b1111_110) begin errors++; $display("[TB] FAIL branch_ctrl got %b expected 1111110", dut_ctrl()); end
    tick();
    checks++;
    if (hif.flush_cnt !== 16'(f0 + 1) || hif.stall_cnt !== 16'(s0)) begin
      errors++;
      $display("[TB] FAIL branch_counters got %0d/%0d expected %0d/%0d", hif.flush_cnt, hif.stall_cnt, f0 + 1, s0);
    end
  endtask

  task automatic test_mem_wait();
    int s0, f0;
    idle_inputs();
    s0 = m_stall; f0 = m_flush;
    hif.mem_access = 1'b1; hif.dmem_ready = 1'b0; hif.ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (dut_ctrl() !== 7'b0000_001) begin errors++; $display("[TB] FAIL wait_freeze_%0d got %b expected 0000001", i, dut_ctrl()); end
      checks++;
      if (hif.state !== ((i == 0) ? 2'b00 : 2'b01)) begin errors++; $display("[TB] FAIL wait_state_%0d got %b", i, hif.state); end
      tick();
    end
    hif.dmem_ready = 1'b1;
    #1;
    checks++;
    if (dut_ctrl() !== 7'b1111_110) begin errors++; $display("[TB] FAIL wait_release_branch got %b expected 1111110", dut_ctrl()); end
    checks++;
    if (hif.stall_cnt !== 16'(s0 + 3)) begin errors++; $display("[TB] FAIL wait_stall got %0d expected %0d", hif.stall_cnt, s0 + 3); end
    tick();
    checks++;
    if (hif.state !== 2'b00 || hif.flush_cnt !== 16'(f0 + 1)) begin
      errors++; $display("[TB] FAIL wait_exit got state %b flush %0d expected 00/%0d", hif.state, hif.flush_cnt, f0 + 1);
    end
  endtask

  task automatic test_timeout();
    int s0;
    idle_inputs();
    hif.mem_access = 1'b1; hif.dmem_ready = 1'b0;
    for (int i = 0; i < T; i++) tick();
    checks++;
    if (hif.state !== 2'b10 || hif.mem_timeout !== 1'b1) begin
      errors++; $display("[TB] FAIL timeout_enter got %b/%b expected 10/1", hif.state, hif.mem_timeout);
    end
    s0 = m_stall;
    hif.dmem_ready = 1'b1; hif.ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (dut_ctrl() !== 7'b0000_001) begin errors++; $display("[TB] FAIL fault_freeze got %b expected 0000001", dut_ctrl()); end
    tick();
    hif.mem_access = 1'b0;
    tick();
    checks++;
    if (hif.state !== 2'b10 || hif.stall_cnt !== 16'(s0)) begin
      errors++; $display("[TB] FAIL fault_sticky got %b stall %0d expected 10/%0d", hif.state, hif.stall_cnt, s0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (hif.state !== 2'b00 || hif.mem_timeout !== 1'b0 || hif.stall_cnt !== 16'd0 || hif.flush_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL fault_reset got %b/%b/%0d/%0d expected 00/0/0/0", hif.state, hif.mem_timeout, hif.stall_cnt, hif.flush_cnt);
    end
    idle_inputs();
    hif.mem_access = 1'b1; hif.dmem_ready = 1'b0;
    for (int i = 0; i < T - 1; i++) tick();
    hif.dmem_ready = 1'b1;
    tick();
    checks++;
    if (hif.state !== 2'b00) begin errors++; $display("[TB] FAIL ready_wins got %b expected 00", hif.state); end
    hif.dmem_ready = 1'b0;
    tick();
    checks++;
    if (hif.state !== 2'b01) begin errors++; $display("[TB] FAIL wait_restart got %b expected 01", hif.state); end
    idle_inputs();
    tick();
  endtask

  task automatic test_saturation();
    idle_inputs();
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd3; hif.id_rs1 = 5'd3;
    for (int i = 0; i < 65540; i++) tick();
    checks++;
    if (hif.stall_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL stall_saturate got %h expected ffff", hif.stall_cnt); end
    hif.clr_cnt = 1'b1;
    tick();
    hif.clr_cnt = 1'b0;
    checks++;
    if (hif.stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL clr_override got %0d expected 0", hif.stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [6:0] exp_c;
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      hif.clr_cnt = ($urandom_range(0, 15) == 0);
      hif.id_rs1 = 5'($urandom_range(0, 3)); hif.id_rs2 = 5'($urandom_range(0, 3));
      hif.ex_rs1 = 5'($urandom_range(0, 3)); hif.ex_rs2 = 5'($urandom_range(0, 3));
      hif.ex_rd  = 5'($urandom_range(0, 3)); hif.mem_rd = 5'($urandom_range(0, 3));
      hif.wb_rd  = 5'($urandom_range(0, 3));
      hif.ex_mem_read = 1'($urandom_range(0, 1)); hif.mem_reg_write = 1'($urandom_range(0, 1));
      hif.wb_reg_write = 1'($urandom_range(0, 1));
      hif.ex_branch_taken = ($urandom_range(0, 3) == 0);
      hif.mem_access = 1'($urandom_range(0, 1));
      hif.dmem_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_c = exp_ctrl();
      if (!(rst && m_state != 0)) begin
        checks++;
        if (dut_ctrl() !== exp_c) begin errors++; $display("[TB] FAIL rnd_ctrl cycle %0d got %b expected %b", n, dut_ctrl(), exp_c); end
      end
      checks++;
      if (hif.fwd_a !== exp_fwd(hif.ex_rs1) || hif.fwd_b !== exp_fwd(hif.ex_rs2)) begin
        errors++; $display("[TB] FAIL rnd_fwd cycle %0d got %b/%b expected %b/%b", n, hif.fwd_a, hif.fwd_b, exp_fwd(hif.ex_rs1), exp_fwd(hif.ex_rs2));
      end
      checks++;
      if (hif.state !== 2'(m_state) || hif.mem_timeout !== (m_state == 2)) begin
        errors++; $display("[TB] FAIL rnd_state cycle %0d got %b/%b expected %0d", n, hif.state, hif.mem_timeout, m_state);
      end
      checks++;
      if (hif.stall_cnt !== 16'(m_stall) || hif.flush_cnt !== 16'(m_flush)) begin
        errors++; $display("[TB] FAIL rnd_counters cycle %0d got %0d/%0d expected %0d/%0d", n, hif.stall_cnt, hif.flush_cnt, m_stall, m_flush);
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
